// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count_sequencer interval timer.
// Holds the controller state encoding and the latched mode encoding.
package count_seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   // True when a latched mode stops the timer after its first terminal count.
   function automatic logic is_oneshot(input logic mode_val);
      return mode_val == MODE_ONESHOT;
   endfunction

endpackage

// File: rtl/count_seq_core.sv
// WIDTH-bit up-counter datapath for count_sequencer: counts up to period_q, then
// returns to zero; terminal is a combinational flag for count == period_q.
module count_seq_core #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] period_q,
   output logic [WIDTH-1:0] count,
   output logic             terminal
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign terminal = (count_q == period_q);
   assign count    = count_q;

   // Wrap happens only through the terminal compare, so P = 2^WIDTH-1 never overflows.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         if (terminal) begin
            count_d = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/count_sequencer.sv
// Programmable interval timer controller around count_seq_core: start/stop/hold
// commands, one-shot or periodic tick, done and err pulses. Optional prescaler
// enabled by defining COUNT_SEQ_PRESCALE_EN.
module count_sequencer
   import count_seq_pkg::*;
#(
   parameter int WIDTH = 4
`ifdef COUNT_SEQ_PRESCALE_EN
   , parameter int PRESCALE_W = 4
`endif
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  hold,
   input  logic                  mode,
   input  logic [WIDTH-1:0]      period,
`ifdef COUNT_SEQ_PRESCALE_EN
   input  logic [PRESCALE_W-1:0] prescale,
`endif
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  tick,
   output logic                  done,
   output logic                  err
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             mode_q, mode_d;
   logic             busy_q, busy_d;
   logic             tick_q, tick_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             latch_cfg;
   logic             core_clear;
   logic             run_step;
   logic             advance;
   logic             core_enable;
   logic             terminal;

   assign latch_cfg   = !stop && start && (period != '0);
   assign core_enable = run_step && advance;

   // Command priority: stop, then start, then hold, then counting.
   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      mode_d     = mode_q;
      tick_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      core_clear = 1'b0;
      run_step   = 1'b0;

      if (stop) begin
         if (state_q == ST_RUN) begin
            state_d    = ST_IDLE;
            core_clear = 1'b1;
         end
      end else if (start) begin
         core_clear = 1'b1;
         if (latch_cfg) begin
            period_d = period;
            mode_d   = mode;
            state_d  = ST_RUN;
         end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end
      end else if ((state_q == ST_RUN) && !hold) begin
         run_step = 1'b1;
         if (advance && terminal) begin
            tick_d = 1'b1;
            if (is_oneshot(mode_q)) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
      end

      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         period_q <= '0;
         mode_q   <= MODE_ONESHOT;
         busy_q   <= 1'b0;
         tick_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         mode_q   <= mode_d;
         busy_q   <= busy_d;
         tick_q   <= tick_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

`ifdef COUNT_SEQ_PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;

   assign advance = (presc_cnt_q == prescale_q);

   // The prescaler only moves on RUN cycles that are not held.
   always_comb begin
      prescale_d  = prescale_q;
      presc_cnt_d = presc_cnt_q;
      if (latch_cfg) begin
         prescale_d = prescale;
      end
      if (core_clear) begin
         presc_cnt_d = '0;
      end else if (run_step) begin
         presc_cnt_d = advance ? '0 : presc_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prescale_q  <= '0;
         presc_cnt_q <= '0;
      end else begin
         prescale_q  <= prescale_d;
         presc_cnt_q <= presc_cnt_d;
      end
   end
`else
   assign advance = 1'b1;
`endif

   count_seq_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clock    (clock),
      .reset    (reset),
      .clear    (core_clear),
      .enable   (core_enable),
      .period_q (period_q),
      .count    (count),
      .terminal (terminal)
   );

   assign busy = busy_q;
   assign tick = tick_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios plus random
// commands, all compared each cycle against a behavioural timer model.
module tb_count_sequencer;

   localparam int W  = 4;
   localparam int PW = 4;

   logic          clock = 1'b0;
   logic          reset, start, stop, hold, mode;
   logic [W-1:0]  period;
   logic [PW-1:0] prescale;
   logic [W-1:0]  count;
   logic          busy, tick, done, err;

   int checks   = 0;
   int failures = 0;

   // Behavioural model of the timer
   bit      m_run;
   int      m_cnt, m_per, m_pre, m_psc;
   bit      m_mode;
   bit      m_tick, m_done, m_err;

   always #5 clock = ~clock;

   count_sequencer #(.WIDTH(W)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .hold     (hold),
      .mode     (mode),
      .period   (period),
`ifdef COUNT_SEQ_PRESCALE_EN
      .prescale (prescale),
`endif
      .count    (count),
      .busy     (busy),
      .tick     (tick),
      .done     (done),
      .err      (err)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit s, input bit p, input bit h,
                             input bit md, input int per, input int psc);
      m_tick = 0; m_done = 0; m_err = 0;
      if (r) begin
         m_run = 0; m_cnt = 0; m_per = 0; m_mode = 0; m_pre = 0; m_psc = 0;
      end else if (p) begin
         if (m_run) begin m_run = 0; m_cnt = 0; m_pre = 0; end
      end else if (s) begin
         m_cnt = 0; m_pre = 0;
         if (per != 0) begin
            m_run = 1; m_per = per; m_mode = md;
`ifdef COUNT_SEQ_PRESCALE_EN
            m_psc = psc;
`endif
         end else begin
            m_run = 0; m_err = 1;
         end
      end else if (m_run && !h) begin
         if (m_pre == m_psc) begin
            m_pre = 0;
            if (m_cnt == m_per) begin
               m_cnt = 0; m_tick = 1;
               if (!m_mode) begin m_done = 1; m_run = 0; end
            end else begin
               m_cnt++;
            end
         end else begin
            m_pre++;
         end
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
   task automatic step(input bit r, input bit s, input bit p, input bit h,
                       input bit md, input int per, input int psc, input string tag);
      reset = r; start = s; stop = p; hold = h; mode = md;
      period = per[W-1:0]; prescale = psc[PW-1:0];
      @(posedge clock);
      model_edge(r, s, p, h, md, per, psc);
      #1;
      chk({tag, ".count"}, int'(count), m_cnt);
      chk({tag, ".busy"},  int'(busy),  int'(m_run));
      chk({tag, ".tick"},  int'(tick),  int'(m_tick));
      chk({tag, ".done"},  int'(done),  int'(m_done));
      chk({tag, ".err"},   int'(err),   int'(m_err));
   endtask

   task automatic idle(input string tag);
      step(0, 0, 0, 0, 0, 0, 0, tag);
   endtask

   initial begin
      int n;
      int ticks;
      bit r, s, p, h, md;
      int per, psc;

      // Reset state
      step(1, 0, 0, 0, 0, 0, 0, "reset");
      step(1, 0, 0, 0, 0, 0, 0, "reset");
      chk("reset_count", int'(count), 0);
      chk("reset_busy", int'(busy), 0);

      // 1: periodic P=3, ticks every 4th cycle, done never set
      step(0, 1, 0, 0, 1, 3, 0, "t1_start");
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         idle("t1_run");
         if (tick) ticks++;
         chk("t1_busy", int'(busy), 1);
         chk("t1_done", int'(done), 0);
      end
      chk("t1_tick_count", ticks, 3);

      // 2: one-shot at P=15
      step(0, 1, 0, 0, 0, 15, 0, "t2_start");
      for (int i = 0; i < 15; i++) idle("t2_run");
      chk("t2_count_max", int'(count), 15);
      idle("t2_term");
      chk("t2_tick", int'(tick), 1);
      chk("t2_done", int'(done), 1);
      chk("t2_busy_after", int'(busy), 0);
      idle("t2_idle");
      chk("t2_tick_clear", int'(tick), 0);

      // 3: hold 3 cycles at count=2, first tick 3 cycles late
      step(0, 1, 0, 0, 1, 4, 0, "t3_start");
      idle("t3_run");
      idle("t3_run");
      chk("t3_count_at_hold", int'(count), 2);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, 1, 4, 0, "t3_hold");
         chk("t3_frozen", int'(count), 2);
      end
      n = 5;
      while (!tick && n < 20) begin
         idle("t3_wait");
         n++;
      end
      chk("t3_first_tick_edge", n, 8);

      // 4: stop on terminal cycle, then start with period 0
      step(0, 1, 0, 0, 1, 3, 0, "t4_start");
      for (int i = 0; i < 3; i++) idle("t4_run");
      chk("t4_at_term", int'(count), 3);
      step(0, 0, 1, 0, 0, 0, 0, "t4_stop");
      chk("t4_no_tick", int'(tick), 0);
      step(0, 1, 0, 0, 1, 0, 0, "t4_err");
      chk("t4_err", int'(err), 1);
      idle("t4_after");
      chk("t4_err_clear", int'(err), 0);
      chk("t4_idle_busy", int'(busy), 0);

      // 5: restart mid-run, then reset mid-run
      step(0, 1, 0, 0, 1, 5, 0, "t5_start");
      idle("t5_run");
      idle("t5_run");
      step(0, 1, 0, 0, 1, 1, 0, "t5_restart");
      chk("t5_restart_count", int'(count), 0);
      idle("t5_r1");
      idle("t5_r2");
      chk("t5_tick", int'(tick), 1);
      idle("t5_r3");
      step(1, 0, 0, 0, 0, 0, 0, "t5_reset");
      chk("t5_reset_busy", int'(busy), 0);
      step(0, 1, 0, 0, 1, 3, 0, "t5_fresh");
      for (int i = 0; i < 8; i++) idle("t5_fresh_run");

`ifdef COUNT_SEQ_PRESCALE_EN
      // 6: prescale=1, P=2 -> tick every 6 cycles
      step(0, 1, 0, 0, 1, 2, 1, "t6_start");
      n = 0;
      while (!tick && n < 20) begin idle("t6_wait"); n++; end
      chk("t6_first_tick", n, 6);
      n = 0;
      do begin idle("t6_gap"); n++; end while (!tick && n < 20);
      chk("t6_tick_spacing", n, 6);
`endif

      // Random commands against the model
      for (int i = 0; i < 600; i++) begin
         r   = ($urandom_range(0, 99) == 0);
         s   = ($urandom_range(0, 11) == 0);
         p   = !s && ($urandom_range(0, 29) == 0);
         h   = ($urandom_range(0, 5) == 0);
         md  = $urandom_range(0, 1) != 0;
         per = $urandom_range(0, 15);
         psc = $urandom_range(0, 3);
         step(r, s, p, h, md, per, psc, $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Controller that sequences a WIDTH-bit up-counter datapath as a programmable interval timer.
- Accepts start/stop/hold commands and latches a period and a mode (one-shot or periodic).
- Emits a one-cycle tick at each terminal count, plus a done pulse when a one-shot completes.
- Sits between control logic and any block that needs a divided clock-enable or timeout strobe.

Parameters:
WIDTH, 4, counter and period width in bits
PRESCALE_W, 4, prescaler width; used only when COUNT_SEQ_PRESCALE_EN is defined

Ports:
clock  in  1  design clock, all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  command pulse: latch period/mode, clear count, enter RUN
stop   in  1  command: abort to IDLE
hold   in  1  level: freeze count while in RUN
mode   in  1  0 = one-shot, 1 = periodic; sampled with start
period in  WIDTH  terminal count value P; sampled with start
count  out WIDTH  current count value
busy   out 1  high while in RUN
tick   out 1  one-cycle pulse at terminal count
done   out 1  one-cycle pulse when a one-shot completes
err    out 1  one-cycle pulse when start is issued with period == 0

Behaviour:
- All outputs are registered. Only clock and reset are always-present inputs.
- Reset (synchronous, highest priority): state = IDLE; count, busy, tick, done and err = 0; latched period/mode = 0. Reset mid-operation aborts with no tick or done.
- Two states:
  - IDLE: count = 0, busy = 0.
  - RUN: busy = 1.
- Priority per edge: reset > stop > start > hold > count advance.
- Start with period != 0 (from any state):
  - Latch period_q and mode_q; count <= 0; state <= RUN.
  - Any terminal event in the same cycle is suppressed.
  - A start during RUN is a restart.
- Start with period == 0: err <= 1 for one cycle; state <= IDLE; count <= 0.
- Stop: state <= IDLE; count <= 0; no tick or done, even if count == period_q in that cycle. A stop in IDLE has no effect.
- RUN with hold = 1: count frozen; no tick.
- RUN, advance cycle:
  - If count != period_q: count <= count + 1.
  - If count == period_q: count <= 0 and tick <= 1.
    - mode_q = 1: stay in RUN.
    - mode_q = 0: done <= 1 in the same cycle as tick; state <= IDLE.
- Timing: start sampled at edge k gives count = 1..P after edges k+1..k+P. Tick is high after edge k+P+1. Periodic tick spacing is P+1 cycles.
- Count wraps only via terminal compare. P = 2^WIDTH-1 is legal; no modular overflow occurs.
- period and mode changes during RUN are ignored until the next start.
- tick, done and err are high for exactly one cycle per event.

Optional Feature:
Macro: COUNT_SEQ_PRESCALE_EN.
- Defined:
  - Adds input prescale [PRESCALE_W-1:0], latched on start.
  - An internal prescaler makes "advance cycle" true once every prescale+1 RUN cycles.
  - The prescaler clears on start, stop and reset, and freezes during hold.
  - Tick spacing = (P+1)*(prescale+1) cycles.
- Not defined: no prescale port; every RUN cycle without hold is an advance cycle.

Decomposition:
- Shared package count_seq_pkg holds:
  - state encodings ST_IDLE and ST_RUN;
  - mode constants MODE_ONESHOT = 1'b0 and MODE_PERIODIC = 1'b1.
- One natural sub-module, count_seq_core: the WIDTH-bit counter datapath.
  - Inputs: clear, enable, period_q.
  - Outputs: count and a combinational terminal flag (count == period_q).
  - The FSM, command priority and pulse generation stay in count_sequencer.

Test Plan:
1. Periodic: reset, mode=1, period=3, start -> count 0,1,2,3,0,1… with tick high every 4th cycle; busy=1 continuously; done never asserted.
2. One-shot at max: mode=0, period=15, start -> count reaches 15; after edge k+16, tick=1 and done=1 in the same cycle; then busy=0 and count=0.
3. Hold: periodic, period=4; hold=1 for 3 cycles while count=2 -> count stays 2; the first tick arrives exactly 3 cycles later than in the no-hold case.
4. Stop/err collision: stop asserted in the cycle where count == period_q -> no tick, state IDLE. Then start with period=0 -> err pulse for one cycle, busy stays 0.
5. Restart and reset: while running period=5 at count=2, start with period=1 -> count=0, first tick 2 cycles later. Next, reset mid-run -> all outputs 0 on the following cycle, and a fresh start behaves as in test 1.
6. (COUNT_SEQ_PRESCALE_EN) prescale=1, period=2, periodic -> count changes every 2 cycles; tick every 6 cycles.
